lsu_writeback: RTL
==================

// Module: lsu_writeback
// PURPOSE
//   Memory-access/write-back stage of the RISC-V pipeline. Accepts one op per handshake from EX,
//   runs loads/stores over a req/ack data-memory bus, aligns and extends load data, and drives
//   the register-file write port (we/waddr/wdata). Non-memory ops pass straight to write-back.
//   While a memory access is outstanding, in_ready is low, which stalls the upstream pipeline.
// PARAMETERS
//   XLEN        32  data/address width
//   RADDR_W     5   register address width (32 architectural registers)
//   MAX_WAIT    15  ack timeout in cycles; 0 disables the timeout
// PORTS
//   clk            in   1        clock
//   rst            in   1        reset, synchronous, active-high
//   in_valid       in   1        EX presents an op
//   in_ready       out  1        stage can accept (state==IDLE)
//   in_mem         in   1        1 = load/store, 0 = ALU result only
//   in_store       in   1        1 = store, 0 = load (valid when in_mem=1)
//   in_funct3      in   3        LB000 LH001 LW010 LBU100 LHU101 / SB000 SH001 SW010
//   in_wen         in   1        op writes rd
//   in_rd          in   RADDR_W  destination register
//   in_result      in   XLEN     ALU result or effective address
//   in_sdata       in   XLEN     store data (rs2)
//   mem_req        out  1        bus request, held until mem_ack
//   mem_we         out  1        1 = write
//   mem_addr       out  XLEN     word-aligned address {in_result[XLEN-1:2],2'b00}
//   mem_be         out  4        byte enables
//   mem_wdata      out  XLEN     lane-replicated store data
//   mem_ack        in   1        one-cycle completion strobe; mem_rdata valid with it
//   mem_rdata      in   XLEN     full read word
//   wb_we          out  1        register-file write enable (never 1 when wb_waddr==0)
//   wb_waddr       out  RADDR_W  register-file write address
//   wb_wdata       out  XLEN     register-file write data
//   err            out  1        one-cycle pulse: misaligned access or ack timeout
// BEHAVIOUR
//   - Reset: state=IDLE, all outputs 0 except in_ready=1. Reset mid-access abandons it;
//     an ack arriving after reset is ignored.
//   - FSM IDLE -> ACCESS -> WB -> IDLE. An op is accepted when in_valid and in_ready are both 1.
//   - ALU op (in_mem=0): no state change. The next cycle drives wb_we=in_wen&(rd!=0),
//     wb_waddr=rd, wb_wdata=in_result for exactly 1 cycle. Back-to-back acceptance is allowed.
//   - Load/store accepted: next cycle enter ACCESS. mem_req=1 with addr/we/be/wdata registered
//     and held stable until the ack cycle. mem_req drops the cycle after mem_ack.
//   - Byte enables: SB 4'b0001<<a[1:0]; SH 4'b0011<<{a[1],1'b0}; SW 4'b1111.
//     wdata: SB {4{b}}, SH {2{h}}, SW word.
//   - Load ack: capture lane(s) selected by a[1:0], then sign-extend (LB/LH) or zero-extend
//     (LBU/LHU). Enter WB: one cycle of wb_we=(rd!=0), then IDLE. Load-use latency =
//     ack cycle + 1. Store ack: go directly to IDLE, with no write-back.
//   - Misaligned (LH/LHU/SH with a[0]=1; LW/SW with a[1:0]!=0): no mem_req, err=1 for 1 cycle,
//     no write-back, stay in IDLE.
//   - Timeout: MAX_WAIT cycles in ACCESS without ack -> err pulse, mem_req=0, no write-back,
//     return to IDLE.
//   - in_ready=0 in ACCESS and WB. Inputs are ignored while in_ready=0.
//   - wb_* outputs hold 0 in every cycle without a write-back (wb_we=0, addr/data=0).
// TESTING
//   - ALU: in_result=0x1234, rd=5, wen=1 -> next cycle wb_we=1, waddr=5, wdata=0x1234, 1 cycle only.
//   - LB @0x1003, ack after 3 cycles with rdata=0x80FF_0000 -> be=4'b1000, wdata(wb)=0xFFFF_FF80,
//     in_ready low until WB done.
//   - LHU @0x2002, rdata=0xBEEF_0000 -> wb 0x0000_BEEF; LH same -> 0xFFFF_BEEF.
//   - SH @0x10 data 0xAABB_CCDD -> be=4'b0011, mem_wdata=0xCCDD_CCDD, no wb_we; SW @0x6 -> err pulse, no req.
//   - Load to rd=0 -> ack completes, wb_we stays 0. Assert rst while in ACCESS -> mem_req=0 next edge;
//     a later ack produces no write.
//   - No ack for 15 cycles -> err on the timeout cycle, in_ready=1 next cycle.

Source files
------------

// File: rtl/lsu_writeback.sv
// Memory-access / write-back stage: runs loads and stores over a req/ack bus,
// aligns and extends load data, and drives the register-file write port.
module lsu_writeback #(
  parameter int XLEN     = 32,
  parameter int RADDR_W  = 5,
  parameter int MAX_WAIT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_mem,
  input  logic               in_store,
  input  logic [2:0]         in_funct3,
  input  logic               in_wen,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic [XLEN-1:0]    in_result,
  input  logic [XLEN-1:0]    in_sdata,
  output logic               mem_req,
  output logic               mem_we,
  output logic [XLEN-1:0]    mem_addr,
  output logic [3:0]         mem_be,
  output logic [XLEN-1:0]    mem_wdata,
  input  logic               mem_ack,
  input  logic [XLEN-1:0]    mem_rdata,
  output logic               wb_we,
  output logic [RADDR_W-1:0] wb_waddr,
  output logic [XLEN-1:0]    wb_wdata,
  output logic               err
);

  localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, WB} state_t;

  state_t             state, state_next;
  logic [RADDR_W-1:0] rd_q;
  logic [2:0]         funct3_q;
  logic [1:0]         lane_q;
  logic               store_q;
  logic [CNT_W-1:0]   wait_cnt;

  logic               accept, misaligned, ack_hit, timeout;
  logic [3:0]         be_next;
  logic [XLEN-1:0]    wdata_next;

  function automatic logic [XLEN-1:0] align_load(input logic [XLEN-1:0] word,
                                                 input logic [1:0] lane,
                                                 input logic [2:0] f3);
    logic [XLEN-1:0] sh;
    sh = word >> {lane, 3'b000};
    case (f3)
      3'b000:  return {{(XLEN-8){sh[7]}}, sh[7:0]};
      3'b001:  return {{(XLEN-16){sh[15]}}, sh[15:0]};
      3'b100:  return {{(XLEN-8){1'b0}}, sh[7:0]};
      3'b101:  return {{(XLEN-16){1'b0}}, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  assign in_ready = (state == IDLE);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    accept     = in_valid && in_ready;
    misaligned = ((in_funct3[1:0] == 2'b01) && in_result[0]) ||
                 (in_funct3[1] && (in_result[1:0] != 2'b00));
    ack_hit    = (state == ACCESS) && mem_req && mem_ack;
    timeout    = (MAX_WAIT != 0) && (state == ACCESS) && mem_req && !mem_ack &&
                 (wait_cnt == CNT_W'(MAX_WAIT - 1));
    be_next    = 4'b1111;
    wdata_next = in_sdata;
    case (in_funct3[1:0])
      2'b00: begin
        be_next    = 4'b0001 << in_result[1:0];
        wdata_next = {4{in_sdata[7:0]}};
      end
      2'b01: begin
        be_next    = 4'b0011 << {in_result[1], 1'b0};
        wdata_next = {2{in_sdata[15:0]}};
      end
      default: ;
    endcase

    state_next = state;
    case (state)
      IDLE:    if (accept && in_mem && !misaligned) state_next = ACCESS;
      // mem_req already low in ACCESS means the timeout cycle is being shown.
      ACCESS:  if (ack_hit) state_next = store_q ? IDLE : WB;
               else if (!mem_req) state_next = IDLE;
      WB:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: reset here is synchronous -- rst is sampled only on the clock edge.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      wb_we     <= 1'b0;
      wb_waddr  <= '0;
      wb_wdata  <= '0;
      err       <= 1'b0;
      rd_q      <= '0;
      funct3_q  <= '0;
      lane_q    <= '0;
      store_q   <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      // Write-back and error are single-cycle pulses unless set below.
      wb_we    <= 1'b0;
      wb_waddr <= '0;
      wb_wdata <= '0;
      err      <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          if (!in_mem) begin
            if (in_wen && (in_rd != '0)) begin
              wb_we    <= 1'b1;
              wb_waddr <= in_rd;
              wb_wdata <= in_result;
            end
          end else if (misaligned) begin
            err <= 1'b1;
          end else begin
            mem_req   <= 1'b1;
            mem_we    <= in_store;
            mem_addr  <= {in_result[XLEN-1:2], 2'b00};
            mem_be    <= be_next;
            mem_wdata <= in_store ? wdata_next : '0;
            rd_q      <= in_rd;
            funct3_q  <= in_funct3;
            lane_q    <= in_result[1:0];
            store_q   <= in_store;
            wait_cnt  <= '0;
          end
        end
        ACCESS: begin
          if (ack_hit || timeout) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
          end
          if (ack_hit) begin
            if (!store_q && (rd_q != '0)) begin
              wb_we    <= 1'b1;
              wb_waddr <= rd_q;
              wb_wdata <= align_load(mem_rdata, lane_q, funct3_q);
            end
          end else if (timeout) begin
            err <= 1'b1;
          end else if (mem_req) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
